// File: rtl/signed_bcd_scan_ctrl.sv
// Signed byte -> sign + 3 BCD digits via serial double-dabble, scanned onto a 4-digit 7-seg display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module signed_bcd_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_value,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_an,
  output logic [6:0] o_seg
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegMinus = 7'b0111111;

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e          r_state;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_mag;
  logic [3:0]      r_hund, r_tens, r_ones;
  logic            r_sign;
  logic [3:0]      r_disp_hund, r_disp_tens, r_disp_ones;
  logic            r_disp_sign;
  logic            r_done;
  logic [DivW-1:0] r_div;
  logic [1:0]      r_idx;

  logic [3:0]  w_hund_adj, w_tens_adj, w_ones_adj;
  logic [19:0] w_shift;
  logic [7:0]  w_mag_in;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] dec7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  assign w_hund_adj = add3(r_hund);
  assign w_tens_adj = add3(r_tens);
  assign w_ones_adj = add3(r_ones);
  // {hund,tens,ones,mag} shifted left by one after the add-3 correction
  assign w_shift    = {w_hund_adj[2:0], w_tens_adj, w_ones_adj, r_mag, 1'b0};
  assign w_mag_in   = i_value[7] ? (~i_value + 8'd1) : i_value;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_bit_cnt   <= 3'd0;
      r_mag       <= 8'd0;
      r_hund      <= 4'd0;
      r_tens      <= 4'd0;
      r_ones      <= 4'd0;
      r_sign      <= 1'b0;
      r_disp_hund <= 4'd0;
      r_disp_tens <= 4'd0;
      r_disp_ones <= 4'd0;
      r_disp_sign <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_load) begin
            r_state   <= StConv;
            r_bit_cnt <= 3'd0;
            r_sign    <= i_value[7];
            r_mag     <= w_mag_in;
            r_hund    <= 4'd0;
            r_tens    <= 4'd0;
            r_ones    <= 4'd0;
          end
        end
        StConv: begin
          r_hund    <= w_shift[19:16];
          r_tens    <= w_shift[15:12];
          r_ones    <= w_shift[11:8];
          r_mag     <= w_shift[7:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_disp_hund <= w_shift[19:16];
            r_disp_tens <= w_shift[15:12];
            r_disp_ones <= w_shift[11:8];
            r_disp_sign <= r_sign;
            r_done      <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= '0;
      r_idx <= 2'd0;
    end else if (r_div == DivMax) begin
      r_div <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign o_busy = (r_state == StConv);
  assign o_done = r_done;
  assign o_an   = ~(4'b0001 << r_idx);

  always_comb begin
    o_seg = SegBlank;
    unique case (r_idx)
      2'd0: o_seg = dec7(r_disp_ones);
      2'd1: begin
        o_seg = dec7(r_disp_tens);
`ifdef LEADING_ZERO_BLANK_EN
        if (r_disp_hund == 4'd0 && r_disp_tens == 4'd0) o_seg = SegBlank;
`endif
      end
      2'd2: begin
        o_seg = dec7(r_disp_hund);
`ifdef LEADING_ZERO_BLANK_EN
        if (r_disp_hund == 4'd0) o_seg = SegBlank;
`endif
      end
      2'd3: o_seg = r_disp_sign ? SegMinus : SegBlank;
    endcase
  end

endmodule

// File: doc/signed_bcd_scan_ctrl.md
# signed_bcd_scan_ctrl

Sequential controller that converts a signed 8-bit value to sign + three BCD digits with a serial shift-add-3 (double-dabble) engine, then time-multiplexes the result onto a 4-digit common-anode 7-segment display. It sits between a producer of signed byte values and the board's shared segment/anode pins. It replaces three parallel combinational decoders with one shared decoder and a digit scanner.

## Interface

- SCAN_DIV, 50000, clock cycles each digit stays enabled; legal range 2 or more.
- clk  in  1  system clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  request to convert `value`; sampled each edge.
- value  in  8  signed two's-complement input.
- busy  out  1  high while a conversion is running.
- done  out  1  one-cycle pulse when the new digits take effect.
- an  out  4  active-low digit enables. an[3] is the sign, an[2] hundreds, an[1] tens, an[0] ones.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.

## Operation

- States:
  - IDLE: busy=0.
  - CONV: busy=1, bit counter 0..7.
- IDLE to CONV: edge with load=1 in IDLE.
  - Capture sign = value[7].
  - Capture mag = value[7] ? (~value+1) : value, as 8-bit unsigned. 8'h80 gives 128.
  - Clear working BCD registers.
- CONV, each edge, for bits 7 down to 0:
  - Add 3 to each working nibble that is ≥5.
  - Then shift {hund,tens,ones,mag} left by one.
- After the 8th CONV edge:
  - Copy working hund/tens/ones/sign to the display registers.
  - Next state IDLE; done=1 for exactly that one cycle.
- load in CONV is ignored, not queued. load in the done cycle is accepted, because the state is IDLE.
- The display shows the previous result for the whole conversion.
- Scanner:
  - Free-running divider 0..SCAN_DIV-1.
  - On each divider wrap, digit index idx advances 0→1→2→3→0.
  - an = ~(4'b0001<<idx).
- Segment decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
  - Blank = 1111111.
- Sign digit (idx 3): 0111111 (minus) when sign=1, blank otherwise.
- Width rule: hundreds is never above 1, and all digits are at most 9. Any non-BCD nibble decodes as blank.

## Timing

- Reset values:
  - State IDLE, busy=0, done=0.
  - Display digits 0/0/0, sign 0.
  - Divider 0, idx 0.
  - an=1110, seg=1000000.
- Latency: load sampled at edge E0.
  - busy=1 in the cycles after E0 through E8.
  - Display registers update at E8; done=1 in the cycle after E8.
  - Total: 9 cycles from load to done.
- an and seg are combinational from idx and the display registers. They change in the cycle after an idx advance or after E8.
- rst mid-conversion: abort at once, return to reset values, no done pulse.
- rst has priority over load on the same edge.

## Configuration

- LEADING_ZERO_BLANK_EN defined:
  - Hundreds digit is blank when it is 0.
  - Tens digit is blank when both hundreds and tens are 0.
  - Ones digit is always shown.
  - After reset: idx 1 and idx 2 are blank.
- Not defined: all three magnitude digits are always shown, including leading zeros.
- The sign digit behaves the same in both builds.

## Test plan

- Reset (SCAN_DIV=4): rst high 2 cycles → busy=0, done=0, an=1110, seg=1000000. Without the macro, an=1101 four cycles later with seg=1000000.
- load=1, value=8'd127 → busy high 8 cycles, done pulse on cycle 9. Scan shows idx0 1111000, idx1 0100100, idx2 1111001, idx3 1111111.
- value=8'h80 (−128) → sign digit 0111111; digits 1, 2, 8 (1111001/0100100/0000000).
- Load 8'd45, then load 8'd99 on the 3rd busy cycle → second load ignored. Display 045 (or 45 with the macro); one done pulse only.
- value=8'hFB (−5):
  - With LEADING_ZERO_BLANK_EN: idx1 and idx2 blank, idx0 0010010, idx3 0111111.
  - Without: idx1 and idx2 show 1000000.
- Load 8'd100, complete, then load 8'd55 and assert rst at the 4th busy cycle → busy=0 next cycle, no done, display reset to 0.
